// File: rtl/store_rs_if.sv
// Dispatch, CDB, flush and issue signals of the store reservation station.
// master = dispatch/CDB/consumer side, slave = the reservation station.
interface store_rs_if #(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6,
    parameter int NCDB   = 2
);
    logic                     flush;
    logic                     disp_valid;
    logic                     disp_ready;
    logic [TAG_W-1:0]         disp_rob;
    logic [DATA_W-1:0]        disp_data1;
    logic [TAG_W-1:0]         disp_q1;
    logic [DATA_W-1:0]        disp_data2;
    logic [TAG_W-1:0]         disp_q2;
    logic [DATA_W-1:0]        disp_offset;
    logic [NCDB-1:0]          cdb_valid;
    logic [NCDB*TAG_W-1:0]    cdb_tag;
    logic [NCDB*DATA_W-1:0]   cdb_data;
    logic                     iss_valid;
    logic                     iss_ready;
    logic [TAG_W-1:0]         iss_rob;
    logic [DATA_W-1:0]        iss_value;
    logic [DATA_W-1:0]        iss_addr;

    modport master (
        output flush, disp_valid, disp_rob, disp_data1, disp_q1, disp_data2, disp_q2,
               disp_offset, cdb_valid, cdb_tag, cdb_data, iss_ready,
        input  disp_ready, iss_valid, iss_rob, iss_value, iss_addr
    );

    modport slave (
        input  flush, disp_valid, disp_rob, disp_data1, disp_q1, disp_data2, disp_q2,
               disp_offset, cdb_valid, cdb_tag, cdb_data, iss_ready,
        output disp_ready, iss_valid, iss_rob, iss_value, iss_addr
    );
endinterface

// File: rtl/store_rs_param.sv
// Parametrised store reservation station: CDB operand capture, oldest-first issue.
// Optional STORE_RS_ALIGN_CHECK_EN adds the iss_misalign output.
module store_rs_param #(
    parameter int DEPTH       = 4,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 6,
    parameter int NCDB        = 2,
    parameter int INVALID_TAG = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    store_rs_if.slave              bus,
    output logic [$clog2(DEPTH):0] occupancy
`ifdef STORE_RS_ALIGN_CHECK_EN
    ,
    output logic                   iss_misalign
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [TAG_W-1:0] INV = TAG_W'(INVALID_TAG);

    typedef struct packed {
        logic              hit;
        logic [DATA_W-1:0] data;
    } snoop_t;

    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busy_nxt;
    logic [DEPTH-1:0]  eligible;
    // age[i][j] = 1 when entry i was dispatched before entry j (diagonal held at 1)
    logic [DEPTH-1:0]  age    [DEPTH];
    logic [TAG_W-1:0]  rob    [DEPTH];
    logic [TAG_W-1:0]  q1     [DEPTH];
    logic [TAG_W-1:0]  q2     [DEPTH];
    logic [DATA_W-1:0] v1     [DEPTH];
    logic [DATA_W-1:0] v2     [DEPTH];
    logic [DATA_W-1:0] offset [DEPTH];
    snoop_t            cap1   [DEPTH];
    snoop_t            cap2   [DEPTH];
    snoop_t            byp1;
    snoop_t            byp2;
    logic              accept;
    logic              load;
    logic              take;
    logic              sel_found;
    logic [IDX_W-1:0]  free_idx;
    logic [IDX_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_addr;

    // Lowest channel index wins when several channels carry the same tag.
    function automatic snoop_t snoop(
        input logic [TAG_W-1:0]       q,
        input logic [NCDB-1:0]        vld,
        input logic [NCDB*TAG_W-1:0]  tags,
        input logic [NCDB*DATA_W-1:0] datas
    );
        snoop_t r;
        r = '0;
        if (q != INV) begin
            for (int k = NCDB - 1; k >= 0; k--) begin
                if (vld[k] && (tags[k*TAG_W +: TAG_W] == q)) begin
                    r.hit  = 1'b1;
                    r.data = datas[k*DATA_W +: DATA_W];
                end
            end
        end
        return r;
    endfunction

    assign bus.disp_ready = ~&busy;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            cap1[i]     = snoop(q1[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            cap2[i]     = snoop(q2[i], bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
            eligible[i] = busy[i] && (q1[i] == INV) && (q2[i] == INV);
        end
        byp1 = snoop(bus.disp_q1, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);
        byp2 = snoop(bus.disp_q2, bus.cdb_valid, bus.cdb_tag, bus.cdb_data);

        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!busy[i]) free_idx = IDX_W'(i);
        end

        // The oldest eligible entry is older than every other eligible entry.
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (eligible[i] && ((eligible & ~age[i]) == '0)) begin
                sel_idx   = IDX_W'(i);
                sel_found = 1'b1;
            end
        end
        sel_addr = v2[sel_idx] + offset[sel_idx];

        accept = bus.disp_valid && bus.disp_ready && !bus.flush;
        load   = !bus.iss_valid || bus.iss_ready;
        take   = load && sel_found && !bus.flush;

        busy_nxt = busy;
        if (take)      busy_nxt[sel_idx]  = 1'b0;
        if (accept)    busy_nxt[free_idx] = 1'b1;
        if (bus.flush) busy_nxt = '0;

        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + {{IDX_W{1'b0}}, busy[i]};
        end
    end

    // Control stage: busy bits and issue register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            busy          <= '0;
            bus.iss_valid <= 1'b0;
            bus.iss_rob   <= INV;
            bus.iss_value <= '0;
            bus.iss_addr  <= '0;
`ifdef STORE_RS_ALIGN_CHECK_EN
            iss_misalign  <= 1'b0;
`endif
        end else begin
            busy <= busy_nxt;
            if (bus.flush) begin
                bus.iss_valid <= 1'b0;
            end else if (load) begin
                bus.iss_valid <= sel_found;
                if (sel_found) begin
                    bus.iss_rob   <= rob[sel_idx];
                    bus.iss_value <= v1[sel_idx];
                    bus.iss_addr  <= sel_addr;
`ifdef STORE_RS_ALIGN_CHECK_EN
                    iss_misalign  <= |sel_addr[1:0];
`endif
                end
            end
        end
    end

    // Entry payload stage: operand capture, dispatch write, age update
    always_ff @(posedge clock) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (busy[i] && cap1[i].hit) begin
                v1[i] <= cap1[i].data;
                q1[i] <= INV;
            end
            if (busy[i] && cap2[i].hit) begin
                v2[i] <= cap2[i].data;
                q2[i] <= INV;
            end
        end
        if (accept) begin
            rob[free_idx]    <= bus.disp_rob;
            offset[free_idx] <= bus.disp_offset;
            v1[free_idx]     <= byp1.hit ? byp1.data : bus.disp_data1;
            q1[free_idx]     <= byp1.hit ? INV : bus.disp_q1;
            v2[free_idx]     <= byp2.hit ? byp2.data : bus.disp_data2;
            q2[free_idx]     <= byp2.hit ? INV : bus.disp_q2;
            for (int j = 0; j < DEPTH; j++) begin
                age[j][free_idx] <= 1'b1;
            end
            age[free_idx] <= DEPTH'(1) << free_idx;
        end
    end
endmodule

// File: tb/tb_store_rs_param.sv
// Directed bench for store_rs_param; issued stores are checked against a scoreboard queue.
module tb_store_rs_param;
    localparam logic [5:0] INV = 6'd16;

    logic       clock;
    logic       reset;
    logic [2:0] occupancy;
`ifdef STORE_RS_ALIGN_CHECK_EN
    logic       iss_misalign;
`endif

    store_rs_if #(.DATA_W(32), .TAG_W(6), .NCDB(2)) bus ();

    store_rs_param #(
        .DEPTH(4), .DATA_W(32), .TAG_W(6), .NCDB(2), .INVALID_TAG(16)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy)
`ifdef STORE_RS_ALIGN_CHECK_EN
        ,
        .iss_misalign (iss_misalign)
`endif
    );

    typedef struct {
        logic [5:0]  rob;
        logic [31:0] value;
        logic [31:0] addr;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_assert++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [5:0] r, input logic [31:0] v, input logic [31:0] a);
        exp_t e;
        e.rob = r; e.value = v; e.addr = a;
        sb.push_back(e);
    endtask

    task automatic dispatch(input logic [5:0] r, input logic [31:0] d1, input logic [5:0] t1,
                            input logic [31:0] d2, input logic [5:0] t2, input logic [31:0] off);
        bus.disp_valid  = 1'b1;
        bus.disp_rob    = r;
        bus.disp_data1  = d1;
        bus.disp_q1     = t1;
        bus.disp_data2  = d2;
        bus.disp_q2     = t2;
        bus.disp_offset = off;
        tick();
        bus.disp_valid  = 1'b0;
    endtask

    task automatic cdb(input logic [1:0] v, input logic [5:0] t0, input logic [31:0] d0,
                       input logic [5:0] t1, input logic [31:0] d1);
        bus.cdb_valid = v;
        bus.cdb_tag   = {t1, t0};
        bus.cdb_data  = {d1, d0};
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) tick();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    // Every valid issue slot must show the scoreboard head; pop on handshake.
    always @(negedge clock) begin
        if (!reset && bus.iss_valid) begin
            chk("issue_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                chk("iss_rob", 32'(bus.iss_rob), 32'(sb[0].rob));
                chk("iss_value", bus.iss_value, sb[0].value);
                chk("iss_addr", bus.iss_addr, sb[0].addr);
`ifdef STORE_RS_ALIGN_CHECK_EN
                chk("iss_misalign", 32'(iss_misalign), 32'(sb[0].addr[1:0] != 2'b00));
`endif
                if (bus.iss_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0; bus.disp_valid = 1'b0; bus.iss_ready = 1'b0;
        bus.disp_rob = '0; bus.disp_data1 = '0; bus.disp_q1 = INV;
        bus.disp_data2 = '0; bus.disp_q2 = INV; bus.disp_offset = '0;
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        #12;
        chk("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("rst_iss_rob", 32'(bus.iss_rob), 32'd16);
        chk("rst_iss_value", bus.iss_value, 32'd0);
        chk("rst_iss_addr", bus.iss_addr, 32'd0);
        chk("rst_occupancy", 32'(occupancy), 32'd0);
        chk("rst_disp_ready", 32'(bus.disp_ready), 32'd1);
        tick();
        reset = 1'b0;

        // Ready operands: issue one cycle after the entry is written
        bus.iss_ready = 1'b1;
        push(6'd3, 32'hAA, 32'h104);
        dispatch(6'd3, 32'hAA, INV, 32'h100, INV, 32'd4);
        chk("s1_occ_after_disp", 32'(occupancy), 32'd1);
        chk("s1_not_yet_valid", 32'(bus.iss_valid), 32'd0);
        tick();
        chk("s1_iss_valid", 32'(bus.iss_valid), 32'd1);
        chk("s1_occ_zero", 32'(occupancy), 32'd0);

        // Value waits for CDB channel 0
        push(6'd5, 32'h55, 32'h308);
        dispatch(6'd5, 32'h0, 6'd7, 32'h300, INV, 32'd8);
        cdb(2'b01, 6'd7, 32'h55, 6'd0, 32'h0);
        tick();
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        chk("s2_no_capture_bypass", 32'(bus.iss_valid), 32'd0);
        tick();
        chk("s2_iss_valid", 32'(bus.iss_valid), 32'd1);

        // Same-cycle bypass of the base from channel 1
        push(6'd6, 32'h77, 32'h200);
        cdb(2'b10, 6'd0, 32'h0, 6'd9, 32'h200);
        dispatch(6'd6, 32'h77, INV, 32'h0, 6'd9, 32'd0);
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        tick();
        chk("s3_iss_valid", 32'(bus.iss_valid), 32'd1);
        drain();

        // Lower channel wins on duplicate tags
        push(6'd8, 32'h11, 32'h30);
        dispatch(6'd8, 32'h0, 6'd12, 32'h10, INV, 32'h20);
        cdb(2'b11, 6'd12, 32'h11, 6'd12, 32'h22);
        tick();
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        drain();

        // Both operands resolve in one cycle; misaligned address still issues
        push(6'd7, 32'h44, 32'h401);
        dispatch(6'd7, 32'h0, 6'd14, 32'h0, 6'd15, 32'd1);
        cdb(2'b11, 6'd14, 32'h44, 6'd15, 32'h400);
        tick();
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        drain();

        // A broadcast of INVALID_TAG must not overwrite a ready operand
        push(6'd9, 32'h33, 32'h40);
        cdb(2'b01, INV, 32'h99, 6'd0, 32'h0);
        dispatch(6'd9, 32'h33, INV, 32'h40, INV, 32'd0);
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        drain();

        // Fill with the consumer stalled
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push(6'(10 + i), 32'h1000 + 32'(i), 32'h2000 + 32'(4 * i));
            dispatch(6'(10 + i), 32'h1000 + 32'(i), INV, 32'h2000, INV, 32'(4 * i));
            if (i == 3) begin
                chk("fill_occ3", 32'(occupancy), 32'd3);
                chk("fill_ready_at3", 32'(bus.disp_ready), 32'd1);
            end
        end
        chk("full_occ4", 32'(occupancy), 32'd4);
        chk("full_disp_ready", 32'(bus.disp_ready), 32'd0);
        bus.disp_valid = 1'b1; bus.disp_rob = 6'd15; bus.disp_q1 = INV; bus.disp_q2 = INV;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("full_refuse_occ", 32'(occupancy), 32'd4);
            chk("full_hold_rob", 32'(bus.iss_rob), 32'd10);
        end
        bus.disp_valid = 1'b0;
        bus.iss_ready  = 1'b1;
        drain();

        // Older entry at a higher index issues first
        push(6'd30, 32'h30, 32'h300);
        push(6'd20, 32'h5A, 32'h500);
        push(6'd21, 32'h5A, 32'h600);
        dispatch(6'd30, 32'h30, INV, 32'h300, INV, 32'd0);
        dispatch(6'd20, 32'h0, 6'd25, 32'h500, INV, 32'd0);
        dispatch(6'd21, 32'h0, 6'd25, 32'h600, INV, 32'd0);
        cdb(2'b01, 6'd25, 32'h5A, 6'd0, 32'h0);
        tick();
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        drain();

        // Flush with three busy entries and a held issue slot; dispatch in the same cycle loses
        bus.iss_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push(6'(40 + i), 32'h40 + 32'(i), 32'h800);
            dispatch(6'(40 + i), 32'h40 + 32'(i), INV, 32'h800, INV, 32'd0);
        end
        tick();
        chk("pre_flush_occ", 32'(occupancy), 32'd3);
        chk("pre_flush_valid", 32'(bus.iss_valid), 32'd1);
        bus.flush = 1'b1;
        bus.disp_valid = 1'b1; bus.disp_rob = 6'd44;
        tick();
        sb.delete();
        bus.flush = 1'b0;
        bus.disp_valid = 1'b0;
        chk("flush_occ", 32'(occupancy), 32'd0);
        chk("flush_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("flush_disp_ready", 32'(bus.disp_ready), 32'd1);
        bus.iss_ready = 1'b1;
        tick();
        tick();
        chk("flush_nothing_left", 32'(bus.iss_valid), 32'd0);

        // Asynchronous reset in the middle of a capture
        bus.iss_ready = 1'b0;
        dispatch(6'd50, 32'h0, 6'd51, 32'h900, INV, 32'd0);
        push(6'd52, 32'h52, 32'h900);
        dispatch(6'd52, 32'h52, INV, 32'h900, INV, 32'd0);
        tick();
        cdb(2'b01, 6'd51, 32'hDEAD, 6'd0, 32'h0);
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        chk("arst_iss_valid", 32'(bus.iss_valid), 32'd0);
        chk("arst_occ", 32'(occupancy), 32'd0);
        chk("arst_disp_ready", 32'(bus.disp_ready), 32'd1);
        chk("arst_iss_rob", 32'(bus.iss_rob), 32'd16);
        tick();
        tick();
        reset = 1'b0;
        cdb(2'b00, 6'd0, 32'd0, 6'd0, 32'd0);
        bus.iss_ready = 1'b1;
        tick();
        tick();
        chk("arst_nothing_left", 32'(bus.iss_valid), 32'd0);
        chk("arst_occ_after", 32'(occupancy), 32'd0);

        // Station still works after reset
        push(6'd60, 32'h66, 32'h710);
        dispatch(6'd60, 32'h66, INV, 32'h700, INV, 32'h10);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
